// File: rtl/sa3_job_scheduler_if.sv
// sa3_job_scheduler_if: bundle of every signal between the job scheduler, its two
// requesters and the shared 3x3 systolic array.
//   Requester side : req0/req1, data0/data1 (4x4 bytes), filt0/filt1 (3x3 bytes),
//                    gnt0/gnt1, done0/done1, result (2x2 bytes), err
//   Array side     : sa_active, sa_a, sa_b (driven by the scheduler), sa_done, sa_c
// Modports:
//   master : the scheduler's view (drives grants, completions and the array inputs)
//   slave  : the environment's view (requesters plus the array)
interface sa3_job_scheduler_if;
    logic         req0;
    logic         req1;
    logic [127:0] data0;
    logic [127:0] data1;
    logic [71:0]  filt0;
    logic [71:0]  filt1;
    logic         gnt0;
    logic         gnt1;
    logic         done0;
    logic         done1;
    logic [31:0]  result;
    logic         err;
    logic         sa_active;
    logic [127:0] sa_a;
    logic [71:0]  sa_b;
    logic         sa_done;
    logic [31:0]  sa_c;

    modport master (
        input  req0, req1, data0, data1, filt0, filt1, sa_done, sa_c,
        output gnt0, gnt1, done0, done1, result, err, sa_active, sa_a, sa_b
    );

    modport slave (
        output req0, req1, data0, data1, filt0, filt1, sa_done, sa_c,
        input  gnt0, gnt1, done0, done1, result, err, sa_active, sa_a, sa_b
    );
endinterface

// File: rtl/sa3_job_scheduler.sv
// sa3_job_scheduler: two-requester round-robin scheduler for the shared 3x3 systolic array.
// A winning requester's data/filter are latched onto the array inputs for one run; the
// 2x2 result is returned as the per-byte difference between the array outputs at done
// and a snapshot taken at grant, because the array accumulators are never cleared.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (the array shares it)
//   bus  : sa3_job_scheduler_if.master (requester handshake and array drive)
// Parameters:
//   WDOG_CYCLES : run-length limit, only used when the watchdog is compiled in
// Build option:
//   SA3_SCHED_WDOG_EN : when defined, a run that lasts WDOG_CYCLES cycles without sa_done
//                       is aborted with err = 1 and result = 0.
module sa3_job_scheduler #(
    parameter int unsigned WDOG_CYCLES = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    sa3_job_scheduler_if.master        bus
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e       state_q, state_d;
    logic         ptr_q, ptr_d;       // last-served requester; 1 after reset so req0 wins a tie
    logic         win_q, win_d;       // requester owning the current run
    logic [127:0] a_q, a_d;
    logic [71:0]  b_q, b_d;
    logic [31:0]  base_q, base_d;
    logic [31:0]  result_q, result_d;
    logic         gnt0_q, gnt0_d;
    logic         gnt1_q, gnt1_d;
    logic         done0_q, done0_d;
    logic         done1_q, done1_d;
    logic         active_q, active_d;
    logic         err_q, err_d;

    logic         any_req;
    logic         pick1;
    logic [31:0]  diff;
    logic         wdog_hit;

    assign any_req = bus.req0 | bus.req1;
    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick1   = bus.req1 & (~bus.req0 | ~ptr_q);

    // Each result byte wraps on its own; no borrow crosses byte lanes.
    always_comb begin
        diff = '0;
        for (int i = 0; i < 4; i++) begin
            diff[8*i +: 8] = bus.sa_c[8*i +: 8] - base_q[8*i +: 8];
        end
    end

`ifdef SA3_SCHED_WDOG_EN
    localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

    logic [WdogW-1:0] wcnt_q, wcnt_d;

    // Counter holds k in the k-th cycle after grant; the abort edge is the one that
    // would take it to WDOG_CYCLES.
    assign wdog_hit = (state_q == StRun) && !bus.sa_done &&
                      (wcnt_q == WdogW'(WDOG_CYCLES - 1));

    always_comb begin
        wcnt_d = wcnt_q;
        if (state_q == StIdle) begin
            if (any_req) begin
                wcnt_d = '0;
            end
        end else begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // State register (plus the registered datapath and outputs).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= 1'b1;
            win_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            base_q   <= '0;
            result_q <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            a_q      <= a_d;
            b_q      <= b_d;
            base_q   <= base_d;
            result_q <= result_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (any_req) state_d = StRun;
            StRun:  if (bus.sa_done || wdog_hit) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        ptr_d    = ptr_q;
        win_d    = win_q;
        a_d      = a_q;
        b_d      = b_q;
        base_d   = base_q;
        result_d = result_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        active_d = active_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                // sa_done seen here is a stale strobe and is ignored.
                if (any_req) begin
                    win_d    = pick1;
                    a_d      = pick1 ? bus.data1 : bus.data0;
                    b_d      = pick1 ? bus.filt1 : bus.filt0;
                    base_d   = bus.sa_c;
                    gnt0_d   = ~pick1;
                    gnt1_d   = pick1;
                    active_d = 1'b1;
                    err_d    = 1'b0;
                end
            end
            StRun: begin
                if (bus.sa_done) begin
                    result_d = diff;
                    done0_d  = ~win_q;
                    done1_d  = win_q;
                    active_d = 1'b0;
                    ptr_d    = win_q;
                end else if (wdog_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done0_d  = ~win_q;
                    done1_d  = win_q;
                    active_d = 1'b0;
                    ptr_d    = win_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.result    = result_q;
    assign bus.err       = err_q;
    assign bus.sa_active = active_q;
    assign bus.sa_a      = a_q;
    assign bus.sa_b      = b_q;

endmodule

// File: tb/tb_sa3_job_scheduler.sv
// Directed bench for sa3_job_scheduler with a behavioural 3x3 array: 17 active cycles per
// run, accumulators updated on entry to the final cycle, sa_done high in that cycle.
module tb_sa3_job_scheduler;

    localparam logic [127:0] Ones128 = {16{8'h01}};
    localparam logic [71:0]  Ones72  = {9{8'h01}};
    // a11..a44 = 1..16, filter with ones on the diagonal only
    localparam logic [127:0] Diag128 = 128'h100F0E0D0C0B0A090807060504030201;
    localparam logic [71:0]  Diag72  = 72'h010000000100000001;

    logic clk;
    logic rst;
    sa3_job_scheduler_if bus ();

    sa3_job_scheduler #(.WDOG_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural array ----------------
    logic [4:0]  mcnt;
    logic [31:0] acc;
    logic        kill_done;
    logic        poke_done;
    logic        preset;

    function automatic logic [31:0] conv(input logic [127:0] a, input logic [71:0] b);
        logic [31:0] c;
        logic [7:0]  s;
        c = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 8'h00;
                for (int k = 0; k < 3; k++) begin
                    for (int l = 0; l < 3; l++) begin
                        s = s + 8'(a[8*((i+k)*4 + (j+l)) +: 8] * b[8*(k*3 + l) +: 8]);
                    end
                end
                c[8*(i*2 + j) +: 8] = s;
            end
        end
        return c;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            mcnt <= '0;
        end else if (preset) begin
            acc <= 32'hFFFF_FFFF;
        end else if (bus.sa_active) begin
            mcnt <= (mcnt == 5'd16) ? 5'd0 : mcnt + 5'd1;
            if (mcnt == 5'd15) begin
                for (int i = 0; i < 4; i++) begin
                    acc[8*i +: 8] <= acc[8*i +: 8] + conv(bus.sa_a, bus.sa_b)[8*i +: 8];
                end
            end
        end
    end

    assign bus.sa_done = (bus.sa_active && (mcnt == 5'd16) && !kill_done) || poke_done;
    assign bus.sa_c    = acc;

    // ---------------- checking ----------------
    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until a done pulse appears; lat = ticks taken, -1 if the budget ran out.
    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.done0 || bus.done1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_done(input string tag, input logic who, input logic [127:0] d,
                              input logic [71:0] f, input logic [31:0] exp_res, input int lat);
        check_eq({tag, " latency"}, 128'(lat), 128'(17));
        check_eq({tag, " done0"}, 128'(bus.done0), 128'(!who));
        check_eq({tag, " done1"}, 128'(bus.done1), 128'(who));
        check_eq({tag, " result"}, 128'(bus.result), 128'(exp_res));
        check_eq({tag, " err"}, 128'(bus.err), 128'(0));
        check_eq({tag, " active"}, 128'(bus.sa_active), 128'(0));
        check_eq({tag, " sa_a held"}, bus.sa_a, d);
        check_eq({tag, " sa_b held"}, 128'(bus.sa_b), 128'(f));
    endtask

    // Single-requester job: grant one cycle after req, done 17 cycles after grant.
    task automatic run_job(input string tag, input logic who, input logic [127:0] d,
                           input logic [71:0] f, input logic [31:0] exp_res);
        int lat;
        if (who) begin
            bus.req1 = 1'b1; bus.data1 = d; bus.filt1 = f;
        end else begin
            bus.req0 = 1'b1; bus.data0 = d; bus.filt0 = f;
        end
        tick();
        check_eq({tag, " gnt0"}, 128'(bus.gnt0), 128'(!who));
        check_eq({tag, " gnt1"}, 128'(bus.gnt1), 128'(who));
        check_eq({tag, " active"}, 128'(bus.sa_active), 128'(1));
        // requester releases and may change its operands after the grant
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.data0 = ~d; bus.data1 = ~d; bus.filt0 = ~f; bus.filt1 = ~f;
        wait_done(40, lat);
        check_done(tag, who, d, f, exp_res, lat);
        tick();
        check_eq({tag, " done pulse"}, 128'(bus.done0 | bus.done1), 128'(0));
        check_eq({tag, " result held"}, 128'(bus.result), 128'(exp_res));
    endtask

    initial begin
        int lat;
        int pulses;
        n_checks  = 0;
        n_fail    = 0;
        kill_done = 1'b0;
        poke_done = 1'b0;
        preset    = 1'b0;
        rst       = 1'b1;
        bus.req0  = 1'b0; bus.req1  = 1'b0;
        bus.data0 = '0;   bus.data1 = '0;
        bus.filt0 = '0;   bus.filt1 = '0;
        tick();
        // reset coinciding with a request: reset wins
        bus.req0 = 1'b1; bus.data0 = Ones128; bus.filt0 = Ones72;
        tick();
        check_eq("rst gnt0", 128'(bus.gnt0), 128'(0));
        check_eq("rst gnt1", 128'(bus.gnt1), 128'(0));
        check_eq("rst done", 128'(bus.done0 | bus.done1), 128'(0));
        check_eq("rst active", 128'(bus.sa_active), 128'(0));
        check_eq("rst sa_a", bus.sa_a, 128'(0));
        check_eq("rst sa_b", 128'(bus.sa_b), 128'(0));
        check_eq("rst result", 128'(bus.result), 128'(0));
        check_eq("rst err", 128'(bus.err), 128'(0));
        bus.req0 = 1'b0;
        rst = 1'b0;
        tick();

        // Tie from reset: pointer = 1 so req0 first; req1 held and granted right after done0.
        bus.req0 = 1'b1; bus.data0 = Ones128; bus.filt0 = Ones72;
        bus.req1 = 1'b1; bus.data1 = Ones128; bus.filt1 = Ones72;
        tick();
        check_eq("tie1 gnt0", 128'(bus.gnt0), 128'(1));
        check_eq("tie1 gnt1", 128'(bus.gnt1), 128'(0));
        bus.req0 = 1'b0;
        wait_done(40, lat);
        check_done("tie1 job0 base0", 1'b0, Ones128, Ones72, 32'h0909_0909, lat);
        tick();
        check_eq("tie1 gnt1 after done0", 128'(bus.gnt1), 128'(1));
        check_eq("tie1 gnt0 quiet", 128'(bus.gnt0), 128'(0));
        bus.req1 = 1'b0;
        wait_done(40, lat);
        check_done("tie1 job1", 1'b1, Ones128, Ones72, 32'h0909_0909, lat);
        tick();

        // Accumulators now hold 18 per byte; base subtraction still yields 9.
        run_job("second", 1'b0, Ones128, Ones72, 32'h0909_0909);

        // Stray sa_done while idle must not complete anything.
        poke_done = 1'b1;
        tick();
        poke_done = 1'b0;
        check_eq("idle sa_done done", 128'(bus.done0 | bus.done1), 128'(0));
        check_eq("idle sa_done active", 128'(bus.sa_active), 128'(0));
        tick();
        check_eq("idle sa_done result", 128'(bus.result), 128'(32'h0909_0909));

        // Base 0xFF per byte: sa_c wraps to 0x08 per byte, difference is 9 in every lane.
        preset = 1'b1;
        tick();
        preset = 1'b0;
        run_job("wrap", 1'b0, Ones128, Ones72, 32'h0909_0909);

        // Tie with req0 served last: req1 first, then req0.
        bus.req0 = 1'b1; bus.data0 = Ones128; bus.filt0 = Ones72;
        bus.req1 = 1'b1; bus.data1 = Diag128; bus.filt1 = Diag72;
        tick();
        check_eq("tie2 gnt1", 128'(bus.gnt1), 128'(1));
        check_eq("tie2 gnt0", 128'(bus.gnt0), 128'(0));
        bus.req1 = 1'b0;
        wait_done(40, lat);
        check_done("tie2 job1", 1'b1, Diag128, Diag72, 32'h211E_1512, lat);
        tick();
        check_eq("tie2 gnt0 after done1", 128'(bus.gnt0), 128'(1));
        bus.req0 = 1'b0;
        wait_done(40, lat);
        check_done("tie2 job0", 1'b0, Ones128, Ones72, 32'h0909_0909, lat);
        tick();

        // Reset 5 cycles after gnt1: everything returns to reset values, no done ever.
        bus.req1 = 1'b1; bus.data1 = Diag128; bus.filt1 = Diag72;
        tick();
        check_eq("abort gnt1", 128'(bus.gnt1), 128'(1));
        bus.req1 = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort active", 128'(bus.sa_active), 128'(0));
        check_eq("abort result", 128'(bus.result), 128'(0));
        check_eq("abort sa_a", bus.sa_a, 128'(0));
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done0 || bus.done1) pulses++;
            tick();
        end
        check_eq("abort no done", 128'(pulses), 128'(0));
        run_job("after abort", 1'b0, Diag128, Diag72, 32'h211E_1512);

`ifdef SA3_SCHED_WDOG_EN
        // Array never finishes: abort exactly 32 cycles after the grant.
        kill_done = 1'b1;
        bus.req0 = 1'b1; bus.data0 = Ones128; bus.filt0 = Ones72;
        tick();
        check_eq("wdog gnt0", 128'(bus.gnt0), 128'(1));
        bus.req0 = 1'b0;
        wait_done(60, lat);
        check_eq("wdog latency", 128'(lat), 128'(32));
        check_eq("wdog done0", 128'(bus.done0), 128'(1));
        check_eq("wdog err", 128'(bus.err), 128'(1));
        check_eq("wdog result", 128'(bus.result), 128'(0));
        check_eq("wdog active", 128'(bus.sa_active), 128'(0));
        tick();
        check_eq("wdog err sticky", 128'(bus.err), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        kill_done = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
